// File: rtl/prog_loader_if.sv
// Signal bundle around the program loader: start/count request, instruction
// stream, CPU write port and the shared memory write port.
interface prog_loader_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [15:0]       word_count;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              cpu_stall;
    logic              pc_reset;
    logic              busy;
    logic              done;
    logic              error;

    // Host side: CPU data path plus the external instruction source.
    modport master (
        output start, word_count, in_valid, in_data, cpu_wr_en, cpu_addr, cpu_data,
        input  in_ready, mem_wr_en, mem_addr, mem_data,
        input  cpu_stall, pc_reset, busy, done, error
    );

    // Loader side.
    modport slave (
        input  start, word_count, in_valid, in_data, cpu_wr_en, cpu_addr, cpu_data,
        output in_ready, mem_wr_en, mem_addr, mem_data,
        output cpu_stall, pc_reset, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: owns the single memory write port while streaming words into
// consecutive addresses, then restarts the CPU at BASE_ADDR.
module prog_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024,
    parameter int                TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_RELEASE,
        S_ERROR
    } state_e;

    localparam int                IDLE_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [16:0]       MAX_COUNT  = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              count_ok;

    assign count_ok = (bus.word_count != 16'd0) && ({1'b0, bus.word_count} <= MAX_COUNT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        idle_d        = idle_q;
        bus.in_ready  = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.pc_reset  = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.error     = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_data  = bus.in_data;

        unique case (state_q)
            S_RUN: begin
                bus.mem_wr_en = bus.cpu_wr_en;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_data  = bus.cpu_data;
                if (bus.start) begin
                    if (count_ok) begin
                        state_d     = S_LOAD;
                        addr_d      = BASE_ADDR;
                        remaining_d = bus.word_count;
                        idle_d      = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end

            S_LOAD: begin
                bus.cpu_stall = 1'b1;
                bus.busy      = 1'b1;
                bus.in_ready  = 1'b1;
                // in_ready is constant here, so a valid beat is an accepted beat
                // and commits to memory on this same edge.
                bus.mem_wr_en = bus.in_valid;
                if (bus.in_valid) begin
                    addr_d      = addr_q + WORD_STEP;
                    remaining_d = remaining_q - 16'd1;
                    idle_d      = '0;
                    if (remaining_q == 16'd1) begin
                        state_d = S_RELEASE;
                    end
                end else if (TIMEOUT != 0) begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == IDLE_LIMIT) begin
                        state_d = S_ERROR;
                    end
                end
            end

            S_RELEASE: begin
                bus.cpu_stall = 1'b1;
                bus.busy      = 1'b1;
                bus.pc_reset  = 1'b1;
                bus.done      = 1'b1;
                state_d       = S_RUN;
            end

            S_ERROR: begin
                bus.cpu_stall = 1'b1;
                bus.error     = 1'b1;
                if (bus.start && count_ok) begin
                    state_d     = S_LOAD;
                    addr_d      = BASE_ADDR;
                    remaining_d = bus.word_count;
                    idle_d      = '0;
                end
            end

            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            addr_q      <= BASE_ADDR;
            remaining_q <= '0;
            idle_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            idle_q      <= idle_d;
        end
    end

`ifndef SYNTHESIS
    a_busy_error_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.busy && bus.error));
    a_done_not_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !((bus.done || bus.pc_reset) && bus.in_ready));
    a_no_write_in_error : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.error && bus.mem_wr_en));
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a cycle-by-cycle vector table, hand-written reset and
// address-wrap sequences, and randomized loads against a transaction-level model.
module tb_prog_loader;

    // Flag order: {in_ready, cpu_stall, busy, error, done, pc_reset}
    localparam logic [5:0] F_RUN  = 6'b000000;
    localparam logic [5:0] F_LOAD = 6'b111000;
    localparam logic [5:0] F_REL  = 6'b011011;
    localparam logic [5:0] F_ERR  = 6'b010100;
    localparam int         TO_A   = 4;
    localparam int         MAX_A  = 8;
    localparam logic [31:0] CA    = 32'h0000_0100;
    localparam logic [31:0] CD    = 32'hBAD0_BAD0;

    typedef struct {
        logic        start;
        logic [15:0] wc;
        logic        in_valid;
        logic [31:0] in_data;
        logic        cpu_wr_en;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_data;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [5:0]  e_flags;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   done_a  = 0;

    prog_loader_if #(.ADDR_W(32)) if_a ();
    prog_loader_if #(.ADDR_W(8))  if_b ();

    prog_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAX_A), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
    );
    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hF8), .MAX_WORDS(4), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [5:0] flags_a();
        return {if_a.in_ready, if_a.cpu_stall, if_a.busy, if_a.error, if_a.done, if_a.pc_reset};
    endfunction

    function automatic logic [5:0] flags_b();
        return {if_b.in_ready, if_b.cpu_stall, if_b.busy, if_b.error, if_b.done, if_b.pc_reset};
    endfunction

    function automatic vec_t mk(logic st, logic [15:0] wc, logic iv, logic [31:0] id,
                                logic cw, logic [31:0] ca, logic [31:0] cd,
                                logic ew, logic [31:0] ea, logic [31:0] ed, logic [5:0] fl);
        vec_t v;
        v.start = st; v.wc = wc; v.in_valid = iv; v.in_data = id;
        v.cpu_wr_en = cw; v.cpu_addr = ca; v.cpu_data = cd;
        v.e_wr = ew; v.e_addr = ea; v.e_data = ed; v.e_flags = fl;
        return v;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Protocol invariants and done-pulse counting, sampled mid-cycle.
    always @(negedge clk) begin
        if (if_a.done === 1'b1) done_a++;
        check("inv_a", {if_a.busy & if_a.error, if_a.done & if_a.in_ready, if_a.pc_reset & if_a.in_ready}, '0);
        check("inv_b", {if_b.busy & if_b.error, if_b.done & if_b.in_ready, if_b.pc_reset & if_b.in_ready}, '0);
    end

    vec_t vecs[22];

    initial begin
        int  done_snap;
        int  done_base;
        int  exp_done;
        bit  in_err;
        int  kb;
        logic [8:0] pat;

        vecs[0]  = mk(1'b0, 16'd0, 1'b0, 32'h0,  1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 32'h40, 32'hDEADBEEF, F_RUN);
        vecs[1]  = mk(1'b1, 16'd3, 1'b0, 32'h0,  1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0,  32'h0,        F_RUN);
        vecs[2]  = mk(1'b0, 16'd0, 1'b1, 32'h11, 1'b1, CA, CD, 1'b1, 32'h0, 32'h11, F_LOAD);
        vecs[3]  = mk(1'b1, 16'd0, 1'b1, 32'h22, 1'b1, CA, CD, 1'b1, 32'h4, 32'h22, F_LOAD);
        vecs[4]  = mk(1'b0, 16'd0, 1'b1, 32'h33, 1'b1, CA, CD, 1'b1, 32'h8, 32'h33, F_LOAD);
        vecs[5]  = mk(1'b0, 16'd0, 1'b0, 32'h0,  1'b1, CA, CD, 1'b0, 32'h0, 32'h0,  F_REL);
        vecs[6]  = mk(1'b0, 16'd0, 1'b0, 32'h0,  1'b1, 32'h80, 32'h12345678, 1'b1, 32'h80, 32'h12345678, F_RUN);
        vecs[7]  = mk(1'b1, 16'd0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, F_RUN);
        vecs[8]  = mk(1'b0, 16'd0, 1'b0, 32'h0,  1'b1, 32'h44, 32'h5555AAAA, 1'b0, 32'h0, 32'h0, F_ERR);
        vecs[9]  = mk(1'b1, 16'(MAX_A + 1), 1'b0, 32'h0, 1'b1, 32'h44, 32'h5555AAAA, 1'b0, 32'h0, 32'h0, F_ERR);
        vecs[10] = mk(1'b0, 16'd0, 1'b0, 32'h0,  1'b1, 32'h44, 32'h5555AAAA, 1'b0, 32'h0, 32'h0, F_ERR);
        vecs[11] = mk(1'b1, 16'd2, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, F_ERR);
        vecs[12] = mk(1'b0, 16'd0, 1'b1, 32'hA5, 1'b1, CA, CD, 1'b1, 32'h0, 32'hA5, F_LOAD);
        vecs[13] = mk(1'b0, 16'd0, 1'b0, 32'h5A, 1'b1, CA, CD, 1'b0, 32'h0, 32'h0, F_LOAD);
        vecs[14] = mk(1'b0, 16'd0, 1'b0, 32'h5A, 1'b1, CA, CD, 1'b0, 32'h0, 32'h0, F_LOAD);
        vecs[15] = mk(1'b0, 16'd0, 1'b0, 32'h5A, 1'b1, CA, CD, 1'b0, 32'h0, 32'h0, F_LOAD);
        vecs[16] = mk(1'b0, 16'd0, 1'b0, 32'h5A, 1'b1, CA, CD, 1'b0, 32'h0, 32'h0, F_LOAD);
        vecs[17] = mk(1'b0, 16'd0, 1'b0, 32'h5A, 1'b1, CA, CD, 1'b0, 32'h0, 32'h0, F_ERR);
        vecs[18] = mk(1'b1, 16'd1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, F_ERR);
        vecs[19] = mk(1'b0, 16'd0, 1'b1, 32'h77, 1'b1, CA, CD, 1'b1, 32'h0, 32'h77, F_LOAD);
        vecs[20] = mk(1'b0, 16'd0, 1'b0, 32'h0,  1'b1, CA, CD, 1'b0, 32'h0, 32'h0, F_REL);
        vecs[21] = mk(1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, F_RUN);

        rst_n = 1'b1;
        if_a.start = 1'b0; if_a.word_count = '0; if_a.in_valid = 1'b0; if_a.in_data = '0;
        if_a.cpu_wr_en = 1'b0; if_a.cpu_addr = '0; if_a.cpu_data = '0;
        if_b.start = 1'b0; if_b.word_count = '0; if_b.in_valid = 1'b0; if_b.in_data = '0;
        if_b.cpu_wr_en = 1'b0; if_b.cpu_addr = '0; if_b.cpu_data = '0;

        // Reset state, with pass-through active while reset is held.
        #2 rst_n = 1'b0;
        #1;
        check("reset.flags_a", flags_a(), F_RUN);
        check("reset.flags_b", flags_b(), F_RUN);
        check("reset.wr_a", if_a.mem_wr_en, 1'b0);
        if_a.cpu_wr_en = 1'b1; if_a.cpu_addr = 32'h40; if_a.cpu_data = 32'hCAFE0001;
        #1;
        check("reset.pass_wr", if_a.mem_wr_en, 1'b1);
        check("reset.pass_addr", if_a.mem_addr, 32'h40);
        if_a.cpu_wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next();

        // Cycle-by-cycle vector table on dut_a.
        for (int i = 0; i < 22; i++) begin
            if_a.start = vecs[i].start; if_a.word_count = vecs[i].wc;
            if_a.in_valid = vecs[i].in_valid; if_a.in_data = vecs[i].in_data;
            if_a.cpu_wr_en = vecs[i].cpu_wr_en; if_a.cpu_addr = vecs[i].cpu_addr;
            if_a.cpu_data = vecs[i].cpu_data;
            @(negedge clk);
            check($sformatf("vec%0d.wr", i), if_a.mem_wr_en, vecs[i].e_wr);
            if (vecs[i].e_wr) begin
                check($sformatf("vec%0d.addr", i), if_a.mem_addr, vecs[i].e_addr);
                check($sformatf("vec%0d.data", i), if_a.mem_data, vecs[i].e_data);
            end
            check($sformatf("vec%0d.flags", i), flags_a(), vecs[i].e_flags);
            next();
        end

        // Reset in the middle of a load.
        done_snap = done_a;
        if_a.start = 1'b1; if_a.word_count = 16'd5; if_a.cpu_wr_en = 1'b0; if_a.in_valid = 1'b0;
        next();
        if_a.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if_a.in_valid = 1'b1; if_a.in_data = 32'hC0 + 32'(k);
            @(negedge clk);
            check("mid.wr", if_a.mem_wr_en, 1'b1);
            check("mid.addr", if_a.mem_addr, 32'(4 * k));
            next();
        end
        if_a.in_valid = 1'b1; if_a.in_data = 32'hC2;
        if_a.cpu_wr_en = 1'b1; if_a.cpu_addr = 32'h60; if_a.cpu_data = 32'hFEEDFACE;
        #1;
        check("mid.pre_flags", flags_a(), F_LOAD);
        check("mid.pre_addr", if_a.mem_addr, 32'h8);
        rst_n = 1'b0;
        #1;
        check("mid.async_flags", flags_a(), F_RUN);
        check("mid.async_wr", if_a.mem_wr_en, 1'b1);
        check("mid.async_addr", if_a.mem_addr, 32'h60);
        check("mid.async_data", if_a.mem_data, 32'hFEEDFACE);
        @(posedge clk);
        @(negedge clk);
        check("mid.held_flags", flags_a(), F_RUN);
        rst_n = 1'b1;
        next();
        @(negedge clk);
        check("mid.after_flags", flags_a(), F_RUN);
        check("mid.after_wr", if_a.mem_wr_en, 1'b1);
        check("mid.after_addr", if_a.mem_addr, 32'h60);
        check("mid.no_done", 64'(done_a - done_snap), 64'd0);
        next();
        if_a.cpu_wr_en = 1'b0; if_a.in_valid = 1'b0;

        // Address wrap on the 8-bit instance, bubbles never time out (TIMEOUT=0).
        if_b.start = 1'b1; if_b.word_count = 16'd3;
        next();
        if_b.start = 1'b0;
        pat = 9'b1_1000_0001;
        kb = 0;
        for (int c = 0; c < 9; c++) begin
            if_b.in_valid = pat[c]; if_b.in_data = 32'hB000 + 32'(c);
            if_b.cpu_wr_en = 1'b1; if_b.cpu_addr = 8'h10; if_b.cpu_data = CD;
            @(negedge clk);
            check("wrap.flags", flags_b(), F_LOAD);
            check("wrap.wr", if_b.mem_wr_en, pat[c]);
            if (pat[c]) begin
                check($sformatf("wrap.addr%0d", kb), if_b.mem_addr, 8'(8'hF8 + 4 * kb));
                check("wrap.data", if_b.mem_data, 32'hB000 + 32'(c));
            end
            next();
            if (pat[c]) kb++;
        end
        if_b.in_valid = 1'b0;
        @(negedge clk);
        check("wrap.release", flags_b(), F_REL);
        check("wrap.release_wr", if_b.mem_wr_en, 1'b0);
        next();
        @(negedge clk);
        check("wrap.run", flags_b(), F_RUN);
        check("wrap.run_addr", if_b.mem_addr, 8'h10);
        next();
        if_b.cpu_wr_en = 1'b0;

        // Randomized loads: expected writes follow BASE + 4*n for the n-th accepted
        // beat; a load ends after word_count beats or TIMEOUT consecutive idle cycles.
        in_err = 1'b0;
        done_base = done_a;
        exp_done = 0;
        for (int t = 0; t < 40; t++) begin
            int  cnt;
            int  gap_at;
            int  acc;
            int  idle;
            int  budget;
            int  n_idle;
            bit  fin;
            n_idle = 1 + int'($urandom_range(0, 2));
            for (int k = 0; k < n_idle; k++) begin
                if_a.start = 1'b0;
                if_a.cpu_wr_en = 1'($urandom); if_a.cpu_addr = $urandom; if_a.cpu_data = $urandom;
                if_a.in_valid = 1'($urandom); if_a.in_data = $urandom;
                @(negedge clk);
                if (in_err) begin
                    check("rnd.err_wr", if_a.mem_wr_en, 1'b0);
                    check("rnd.err_flags", flags_a(), F_ERR);
                end else begin
                    check("rnd.run_wr", if_a.mem_wr_en, if_a.cpu_wr_en);
                    check("rnd.run_addr", if_a.mem_addr, if_a.cpu_addr);
                    check("rnd.run_data", if_a.mem_data, if_a.cpu_data);
                    check("rnd.run_flags", flags_a(), F_RUN);
                end
                next();
            end
            cnt = int'($urandom_range(0, MAX_A + 2));
            if_a.start = 1'b1; if_a.word_count = 16'(cnt); if_a.cpu_wr_en = 1'b0; if_a.in_valid = 1'b0;
            @(negedge clk);
            check("rnd.start_wr", if_a.mem_wr_en, 1'b0);
            check("rnd.start_flags", flags_a(), in_err ? F_ERR : F_RUN);
            next();
            if_a.start = 1'b0;
            if (cnt < 1 || cnt > MAX_A) begin
                in_err = 1'b1;
            end else begin
                in_err = 1'b0;
                gap_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
                acc = 0; idle = 0; budget = 300; fin = 1'b0;
                while (!fin && budget > 0) begin
                    budget--;
                    if_a.cpu_wr_en = 1'b1; if_a.cpu_addr = $urandom; if_a.cpu_data = $urandom;
                    if_a.in_valid = (acc == gap_at) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
                    if_a.in_data = $urandom;
                    @(negedge clk);
                    check("rnd.load_flags", flags_a(), F_LOAD);
                    check("rnd.load_wr", if_a.mem_wr_en, if_a.in_valid);
                    if (if_a.in_valid) begin
                        check("rnd.load_addr", if_a.mem_addr, 32'(4 * acc));
                        check("rnd.load_data", if_a.mem_data, if_a.in_data);
                        acc++;
                        idle = 0;
                    end else begin
                        idle++;
                    end
                    next();
                    if (acc == cnt) begin
                        if_a.in_valid = 1'b0;
                        @(negedge clk);
                        check("rnd.rel_flags", flags_a(), F_REL);
                        check("rnd.rel_wr", if_a.mem_wr_en, 1'b0);
                        exp_done++;
                        next();
                        fin = 1'b1;
                    end else if (idle == TO_A) begin
                        in_err = 1'b1;
                        fin = 1'b1;
                    end
                end
                if (!fin) check("rnd.budget", 64'd0, 64'd1);
            end
        end
        @(negedge clk);
        check("rnd.done_count", 64'(done_a - done_base), 64'(exp_done));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
